// File: rtl/data_ram_avalon.sv
// Word-organised data RAM behind an Avalon-style slave port.
// Every request is held off with waitrequest for WAIT_CYCLES cycles and then
// completes in its accept cycle. Byte addresses are relative to BASE_ADDR and
// are checked for alignment and range; a bad access is accepted but only
// pulses error.
module data_ram_avalon #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 65536,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    error
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [7:0]            WAIT_CNT = 8'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] ram [DEPTH_WORDS];

    logic [7:0]            cnt;
    logic                  req;
    logic                  accept;
    logic                  misaligned;
    logic                  below_base;
    logic                  out_of_range;
    logic                  bad;
    logic                  good_wr;
    logic                  good_rd;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx_full;
    logic [IDX_W-1:0]      idx;

    // Address decode: word index relative to the base, plus the bad-access checks.
    assign offset   = address - BASE_ADDR;
    assign idx_full = offset >> LANE_BITS;
    assign idx      = idx_full[IDX_W-1:0];

    generate
        if (LANE_BITS > 0) begin : g_align
            assign misaligned = |address[LANE_BITS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    assign below_base   = (address < BASE_ADDR);
    assign out_of_range = (idx_full >= DEPTH_A);
    assign bad          = misaligned | below_base | out_of_range | (read & write);

    // Handshake: reset holds the bus off; otherwise stall until cnt reaches WAIT_CYCLES.
    assign req         = read | write;
    assign waitrequest = reset | (req & (cnt != WAIT_CNT));
    assign accept      = req & ~waitrequest;
    assign good_wr     = accept & write & ~bad;
    assign good_rd     = accept & read & ~bad;
    assign error       = accept & bad;

    // Stall counter: counts stalled request cycles, clears on accept or when req drops.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (req && waitrequest) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Storage: byte-lane write in the accept cycle of a good write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch so it maps onto RAM macros; contents survive reset.
        if (good_wr) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byteenable[i]) begin
                    ram[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Read port: full word during a good read's accept cycle, zero otherwise.
    always_comb begin
        // NOTE: assigning the default first keeps this block free of inferred latches.
        readdata = '0;
        if (good_rd) begin
            readdata = ram[idx];
        end
    end

endmodule
